// File: rtl/mvu_run_controller.sv
// mvu_run_controller: supervises NMVU matrix-vector units. Each channel
// accepts one job at a time, times it, optionally aborts it on timeout and
// reports a result through a round-robin arbitrated result port.
//
// state    | meaning
// S_IDLE   | channel free, may accept a command
// S_START  | start pulse cycle
// S_BUSY   | job running, counting cycles, watching done/timeout
// S_REPORT | result waiting for retirement on the result port
module mvu_run_controller #(
    parameter int NMVU      = 8,
    parameter int TIMEOUT_W = 24,
    localparam int CW       = (NMVU > 1) ? $clog2(NMVU) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CW-1:0]        cmd_chan,
    input  logic [TIMEOUT_W-1:0] cmd_timeout,
    output logic [NMVU-1:0]      mvu_start,
    input  logic [NMVU-1:0]      mvu_done,
    output logic [NMVU-1:0]      mvu_abort,
    output logic [NMVU-1:0]      busy,
    output logic [NMVU-1:0]      spurious,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CW-1:0]        res_chan,
    output logic [1:0]           res_status,
    output logic [TIMEOUT_W-1:0] res_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_REPORT} state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_t               st_q  [NMVU];
    state_t               st_d  [NMVU];
    logic [TIMEOUT_W-1:0] cnt_q [NMVU];
    logic [TIMEOUT_W-1:0] cnt_d [NMVU];
    logic [TIMEOUT_W-1:0] tmo_q [NMVU];
    logic [TIMEOUT_W-1:0] tmo_d [NMVU];
    logic [TIMEOUT_W-1:0] cyc_q [NMVU];
    logic [TIMEOUT_W-1:0] cyc_d [NMVU];
    logic [NMVU-1:0]      tout_q, tout_d;
    logic [NMVU-1:0]      abort_q, abort_d;
    logic [NMVU-1:0]      spur_q, spur_d;
    logic [NMVU-1:0]      in_report;
    logic [CW-1:0]        rr_q, rr_d, gnt_q, gnt_d, pick, grant;
    logic                 hold_q, hold_d;
    logic                 run_q;

    // Keep cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // Command acceptance depends only on the addressed channel being idle.
    always_comb begin
        cmd_ready = 1'b0;
        for (int i = 0; i < NMVU; i++) begin
            if (run_q && int'(cmd_chan) == i && st_q[i] == S_IDLE) cmd_ready = 1'b1;
        end
    end

    // Per-channel status decode.
    always_comb begin
        mvu_start = '0;
        busy      = '0;
        in_report = '0;
        for (int i = 0; i < NMVU; i++) begin
            mvu_start[i] = (st_q[i] == S_START);
            busy[i]      = (st_q[i] != S_IDLE);
            in_report[i] = (st_q[i] == S_REPORT);
        end
    end

    assign mvu_abort = abort_q;
    assign spurious  = spur_q;
    assign res_valid = |in_report;

    // Round-robin search for a reporting channel starting at rr_q.
    always_comb begin
        logic          found;
        logic [CW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NMVU; k++) begin
            idx = CW'((int'(rr_q) + k) % NMVU);
            if (!found && in_report[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Once a result is presented it stays granted until it is taken.
    assign grant = hold_q ? gnt_q : pick;

    assign res_chan   = res_valid ? grant : '0;
    assign res_status = res_valid ? {1'b0, tout_q[grant]} : 2'b00;
    assign res_cycles = res_valid ? cyc_q[grant] : '0;

    // Arbiter next state: lock the grant while stalled, advance pointer on retire.
    always_comb begin
        rr_d   = rr_q;
        gnt_d  = gnt_q;
        hold_d = hold_q;
        if (res_valid && res_ready) begin
            hold_d = 1'b0;
            rr_d   = (int'(grant) == NMVU - 1) ? '0 : grant + 1'b1;
        end else if (res_valid) begin
            hold_d = 1'b1;
            gnt_d  = grant;
        end
    end

    // Arbiter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= '0;
            gnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            gnt_q  <= gnt_d;
            hold_q <= hold_d;
        end
    end

    // Channel FSM next state, job counter and result capture.
    always_comb begin
        tout_d  = tout_q;
        abort_d = '0;
        spur_d  = spur_q;
        for (int i = 0; i < NMVU; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            tmo_d[i] = tmo_q[i];
            cyc_d[i] = cyc_q[i];
            if (mvu_done[i] && st_q[i] != S_BUSY) spur_d[i] = 1'b1;
            case (st_q[i])
                S_IDLE: begin
                    if (cmd_valid && cmd_ready && int'(cmd_chan) == i) begin
                        st_d[i]  = S_START;
                        tmo_d[i] = cmd_timeout;
                        cnt_d[i] = '0;
                    end
                end
                S_START: st_d[i] = S_BUSY;
                S_BUSY: begin
                    if (mvu_done[i]) begin
                        cyc_d[i]  = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
                        tout_d[i] = 1'b0;
                        st_d[i]   = S_REPORT;
                    end else if (tmo_q[i] != '0 && cnt_q[i] + 1'b1 == tmo_q[i]) begin
                        cyc_d[i]   = tmo_q[i];
                        tout_d[i]  = 1'b1;
                        abort_d[i] = 1'b1;
                        st_d[i]    = S_REPORT;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res_valid && res_ready && int'(grant) == i) st_d[i] = S_IDLE;
                end
                default: st_d[i] = S_IDLE;
            endcase
        end
    end

    // Channel registers; reset drops any job in flight silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NMVU; i++) begin
                st_q[i]  <= S_IDLE;
                cnt_q[i] <= '0;
                tmo_q[i] <= '0;
                cyc_q[i] <= '0;
            end
            tout_q  <= '0;
            abort_q <= '0;
            spur_q  <= '0;
        end else begin
            for (int i = 0; i < NMVU; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                tmo_q[i] <= tmo_d[i];
                cyc_q[i] <= cyc_d[i];
            end
            tout_q  <= tout_d;
            abort_q <= abort_d;
            spur_q  <= spur_d;
        end
    end

endmodule

// File: tb/tb_mvu_run_controller.sv
// Scoreboard bench for mvu_run_controller: directed jobs push expected
// results; a negedge monitor pops and compares on every result handshake.
module tb_mvu_run_controller;

    localparam int NMVU = 6;
    localparam int TW   = 8;
    localparam int CW   = 3;

    logic            clk, rst_n;
    logic            cmd_valid, cmd_ready;
    logic [CW-1:0]   cmd_chan;
    logic [TW-1:0]   cmd_timeout;
    logic [NMVU-1:0] mvu_start, mvu_done, mvu_abort, busy, spurious;
    logic            res_valid, res_ready;
    logic [CW-1:0]   res_chan;
    logic [1:0]      res_status;
    logic [TW-1:0]   res_cycles;

    mvu_run_controller #(.NMVU(NMVU), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
        .cmd_timeout(cmd_timeout),
        .mvu_start(mvu_start), .mvu_done(mvu_done), .mvu_abort(mvu_abort),
        .busy(busy), .spurious(spurious),
        .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
        .res_status(res_status), .res_cycles(res_cycles)
    );

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [1:0]    st;
        logic [TW-1:0] cyc;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   vecs = 0;
    int   errs = 0;
    int   start_cnt[NMVU];
    int   abort_cnt[NMVU];
    int   snap_s, snap_a, sum_s, sum_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int st, input int cyc);
        res_t e;
        e.ch  = CW'(ch);
        e.st  = 2'(st);
        e.cyc = TW'(cyc);
        exp_q.push_back(e);
    endtask

    // Returns at the first BUSY cycle of the job (posedge + 1).
    task automatic issue(input int ch, input int tmo);
        cmd_valid   = 1'b1;
        cmd_chan    = CW'(ch);
        cmd_timeout = TW'(tmo);
        @(negedge clk);
        check("cmd_ready_accept", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mvu_start_pulse", 32'(mvu_start), 32'(1 << ch));
        tick();
    endtask

    task automatic pulse(input logic [NMVU-1:0] m);
        mvu_done = m;
        tick();
        mvu_done = '0;
    endtask

    task automatic sums();
        sum_s = 0;
        sum_a = 0;
        for (int i = 0; i < NMVU; i++) begin
            sum_s += start_cnt[i];
            sum_a += abort_cnt[i];
        end
    endtask

    // Monitor: count pulses and check every retired result against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NMVU; i++) begin
                if (mvu_start[i]) start_cnt[i]++;
                if (mvu_abort[i]) abort_cnt[i]++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res_chan), 32'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_chan", 32'(res_chan), 32'(mon_e.ch));
                    check("res_status", 32'(res_status), 32'(mon_e.st));
                    check("res_cycles", 32'(res_cycles), 32'(mon_e.cyc));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NMVU; i++) begin
            start_cnt[i] = 0;
            abort_cnt[i] = 0;
        end
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_chan = '0; cmd_timeout = '0;
        mvu_done = '0; res_ready = 1'b1;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_outputs", {res_chan, res_status, res_cycles, mvu_start, mvu_abort, spurious}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        tick();

        // Basic OK job: ch 2, done 5 cycles after first BUSY.
        push(2, 0, 6);
        issue(2, 100);
        tick(5);
        pulse(6'b000100);
        tick(3);
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_start_once", start_cnt[2], 1);

        // Timeout on ch 0, then done exactly on the expiry cycle.
        push(0, 1, 10);
        issue(0, 10);
        tick(12);
        check("t2_abort_once", abort_cnt[0], 1);
        check("t2_busy_idle", 32'(busy), 0);
        push(0, 0, 10);
        issue(0, 10);
        tick(9);
        pulse(6'b000001);
        tick(3);
        check("t2_no_abort_on_done", abort_cnt[0], 1);

        // Three simultaneous completions with a stalled result port.
        res_ready = 1'b0;
        push(1, 0, 5);
        push(3, 0, 3);
        push(5, 0, 1);
        issue(1, 0);
        issue(3, 0);
        issue(5, 0);
        pulse(6'b101010);
        repeat (4) begin
            @(negedge clk);
            check("t3_stall_valid", 32'(res_valid), 1);
            check("t3_stall_chan", 32'(res_chan), 1);
            check("t3_stall_cycles", 32'(res_cycles), 5);
        end
        tick();
        res_ready = 1'b1;
        tick(4);
        check("t3_drained", exp_q.size(), 0);

        // Grant stays locked when a channel nearer the pointer reports later.
        res_ready = 1'b0;
        push(1, 0, 3);
        push(0, 0, 3);
        issue(1, 0);
        issue(0, 0);
        pulse(6'b000010);
        tick();
        pulse(6'b000001);
        repeat (2) begin
            @(negedge clk);
            check("t3b_hold_chan", 32'(res_chan), 1);
            check("t3b_hold_cycles", 32'(res_cycles), 3);
        end
        tick();
        res_ready = 1'b1;
        tick(4);
        check("t3b_drained", exp_q.size(), 0);

        // Busy channel blocks commands until one cycle after its handshake.
        push(2, 0, 4);
        issue(2, 0);
        cmd_chan = 3'd2;
        repeat (3) begin
            @(negedge clk);
            check("t4_busy_blocked", 32'(cmd_ready), 0);
        end
        tick();
        pulse(6'b000100);
        @(negedge clk);
        check("t4_handshake_cycle", 32'(cmd_ready), 0);
        tick();
        @(negedge clk);
        check("t4_ready_after", 32'(cmd_ready), 1);
        tick();
        cmd_chan = 3'd6;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_bad_chan", 32'(cmd_ready), 0);
        end
        tick();
        cmd_valid = 1'b0;
        check("t4_bad_chan_idle", 32'(busy), 0);
        check("t4_no_spurious", 32'(spurious), 0);

        // Spurious done on idle ch 4.
        pulse(6'b010000);
        tick(3);
        check("t5_spurious", 32'(spurious), 32'h10);

        // Timeout 0: counter saturates and job ends only on done.
        push(3, 0, 255);
        issue(3, 0);
        tick(300);
        check("t6_still_busy", 32'(busy), 32'h08);
        pulse(6'b001000);
        tick(3);
        check("t6_done_idle", 32'(busy), 0);
        check("t6_spurious_held", 32'(spurious), 32'h10);

        // Reset with three channels busy and one stalled in REPORT.
        res_ready = 1'b0;
        issue(3, 0);
        pulse(6'b001000);
        issue(0, 0);
        issue(1, 0);
        issue(2, 0);
        cmd_chan = 3'd4;
        @(negedge clk);
        check("t7_pre_busy", 32'(busy), 32'h0F);
        check("t7_pre_valid", 32'(res_valid), 1);
        sums();
        snap_s = sum_s;
        snap_a = sum_a;
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_ready", 32'(cmd_ready), 0);
        check("t7_rst_valid", 32'(res_valid), 0);
        check("t7_rst_outputs", {res_chan, res_status, res_cycles, mvu_start, mvu_abort, spurious}, 0);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick(20);
        sums();
        check("t7_no_start_after", sum_s, snap_s);
        check("t7_no_abort_after", sum_a, snap_a);
        check("t7_idle_after", 32'(busy), 0);
        push(4, 1, 3);
        issue(4, 3);
        tick(8);
        check("t7_abort_after_reset", abort_cnt[4], 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mvu_run_controller.md
MVU_RUN_CONTROLLER -- requirements
Module: mvu_run_controller

Interface
REQ-001 Parameter NMVU, default 8, number of MVU channels supervised (1..32).
REQ-002 Parameter TIMEOUT_W, default 24, width of per-job timeout and cycle counters.
REQ-003 Localparam CW = max(1, clog2(NMVU)), channel index width.
REQ-004 Reset is asynchronous and active-low; single clock; ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  host job request valid.
REQ-006 cmd_ready  out  1  request accepted when cmd_valid && cmd_ready.
REQ-007 cmd_chan  in  CW  target channel.
REQ-008 cmd_timeout  in  TIMEOUT_W  timeout in cycles; 0 = no timeout.
REQ-009 mvu_start  out  NMVU  one-cycle start pulse per channel.
REQ-010 mvu_done  in  NMVU  one-cycle completion pulse per channel.
REQ-011 mvu_abort  out  NMVU  one-cycle abort pulse per channel on timeout.
REQ-012 busy  out  NMVU  channel not IDLE.
REQ-013 spurious  out  NMVU  sticky: mvu_done seen while channel not BUSY.
REQ-014 res_valid  out  1; res_ready  in  1; res_chan  out  CW; res_status  out  2 (00 OK, 01 TIMEOUT); res_cycles  out  TIMEOUT_W.

Function
REQ-015 Each channel has FSM IDLE -> START -> BUSY -> REPORT -> IDLE.
REQ-016 cmd_ready = (cmd_chan < NMVU) && channel[cmd_chan] in IDLE; combinational from state.
REQ-017 Accept in cycle T: channel enters START at T+1, mvu_start[ch] high exactly in T+1, BUSY from T+2; timeout and counter latched at accept, counter cleared.
REQ-018 mvu_done is sampled only in BUSY; done during START/REPORT/IDLE sets spurious[ch] and is otherwise ignored.
REQ-019 In BUSY each cycle: if done -> res_cycles = cnt+1, status OK, go REPORT; else if timeout != 0 and cnt+1 == timeout -> status TIMEOUT, res_cycles = timeout, mvu_abort[ch] pulsed next cycle, go REPORT; else cnt increments.
REQ-020 Done and timeout expiry in the same cycle: done wins (status OK).
REQ-021 With timeout 0 the counter saturates at 2^TIMEOUT_W-1 and never wraps; job ends only on done.
REQ-022 res_valid = any channel in REPORT; result fields come from the granted channel's registers.
REQ-023 Grant is round-robin: search starts at channel after last completed grant (initially 0).
REQ-024 While res_valid && !res_ready, grant and all res_* fields SHALL remain stable even if other channels enter REPORT.
REQ-025 On res_valid && res_ready the granted channel returns to IDLE next cycle; the round-robin pointer moves to grant+1 mod NMVU.
REQ-026 A channel returning to IDLE can accept a new command the cycle after handshake; no same-cycle reuse.
REQ-027 Independent channels run concurrently; at most one command accepted and one result retired per cycle.

Reset
REQ-028 rst_n low asynchronously forces all channels IDLE, counters 0, rr pointer 0, spurious 0.
REQ-029 During reset: cmd_ready 0, mvu_start 0, mvu_abort 0, busy 0, res_valid 0, res_chan 0, res_status 0, res_cycles 0.
REQ-030 Reset mid-job drops the job with no result and no abort pulse; deassertion is synchronous to the clock edge.

Verification
REQ-031 ch 2, timeout 100, done 5 cycles after first BUSY -> single mvu_start[2] at T+1, result chan 2, status OK, cycles 6.
REQ-032 ch 0, timeout 10, no done -> mvu_abort[0] one cycle, result status TIMEOUT, cycles 10; done on expiry cycle instead -> OK, cycles 10.
REQ-033 Jobs on ch 1,3,5 finish same cycle, res_ready held low 4 cycles -> fields stable while stalled, then retired in order 1,3,5.
REQ-034 Command to busy channel -> cmd_ready 0 until that channel's result handshake +1 cycle; chan >= NMVU -> never accepted.
REQ-035 Done pulse on IDLE ch 4 -> spurious[4] set and held until reset, no result produced.
REQ-036 rst_n asserted while 3 channels BUSY and one in REPORT stalled -> all outputs to reset values immediately, no pulses after release.
